// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// The master drives the parallel load side; the slave is the serializer itself.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] din;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid,
        output din,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  load_valid,
        input  din,
        output load_ready,
        output sout,
        output sout_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, one bit per clock, valid/ready load with back-to-back frames.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit after each data word.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    piso_serializer_if.slave       bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PISO_SERIALIZER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             last_bit_s;
    logic             final_cycle_s;
    logic             accept_s;
    logic             data_bit_s;
    logic [WIDTH-1:0] shifted_s;

`ifdef PISO_SERIALIZER_PARITY_EN
    logic             par_r;
    logic             par_s;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    assign last_bit_s = (state_r == SHIFT) && (cnt_r == CW'(WIDTH - 1));
    assign data_bit_s = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];
    assign shifted_s  = MSB_FIRST ? {shreg_r[WIDTH-2:0], 1'b0} : {1'b0, shreg_r[WIDTH-1:1]};

`ifdef PISO_SERIALIZER_PARITY_EN
    assign final_cycle_s = (state_r == PARITY);
`else
    assign final_cycle_s = last_bit_s;
`endif

    // Outputs depend only on registered state, so reset clears them without a clock edge.
    assign bus.load_ready = (state_r == IDLE) || final_cycle_s;
    assign bus.sout_valid = (state_r != IDLE);
    assign bus.busy       = (state_r != IDLE);
    assign bus.done       = final_cycle_s;
    assign accept_s       = bus.load_valid && bus.load_ready;

`ifdef PISO_SERIALIZER_PARITY_EN
    assign bus.sout = (state_r == SHIFT) ? data_bit_s : ((state_r == PARITY) ? par_r : 1'b0);
`else
    assign bus.sout = (state_r == SHIFT) ? data_bit_s : 1'b0;
`endif

    // State, shift register and bit counter update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
`ifdef PISO_SERIALIZER_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            cnt_r   <= cnt_s;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_r   <= par_s;
`endif
        end
    end

    // Next-state logic: an accepted load always restarts a frame from the new word.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        cnt_s   = cnt_r;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_s   = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                    shreg_s = bus.din;
                    cnt_s   = {CW{1'b0}};
`ifdef PISO_SERIALIZER_PARITY_EN
                    par_s   = even_parity(bus.din);
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                    state_s = PARITY;
                    shreg_s = shifted_s;
                    cnt_s   = {CW{1'b0}};
`else
                    if (accept_s) begin
                        state_s = SHIFT;
                        shreg_s = bus.din;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        state_s = IDLE;
                        shreg_s = shifted_s;
                        cnt_s   = {CW{1'b0}};
                    end
`endif
                end else begin
                    shreg_s = shifted_s;
                    cnt_s   = cnt_r + CW'(1);
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            PARITY: begin
                if (accept_s) begin
                    state_s = SHIFT;
                    shreg_s = bus.din;
                    cnt_s   = {CW{1'b0}};
                    par_s   = even_parity(bus.din);
                end else begin
                    state_s = IDLE;
                end
            end
`endif
            default: begin
                state_s = IDLE;
                shreg_s = {WIDTH{1'b0}};
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_piso_serializer;
    localparam int W = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = W + PAR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    piso_serializer_if #(.WIDTH(W)) bm ();
    piso_serializer_if #(.WIDTH(W)) bl ();

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(bm.slave));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(bl.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] exp_msb;   // first bit sent is bit W-1
        logic [W-1:0] exp_lsb;
        logic         exp_par;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, input logic [W-1:0] d);
        bm.load_valid = lv;
        bl.load_valid = lv;
        bm.din        = d;
        bl.din        = d;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " msb load_ready"}, {31'd0, bm.load_ready}, 32'd1);
        chk({tag, " msb sout_valid"}, {31'd0, bm.sout_valid}, 32'd0);
        chk({tag, " msb busy"},       {31'd0, bm.busy},       32'd0);
        chk({tag, " lsb sout_valid"}, {31'd0, bl.sout_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{din: 4'b1011, exp_msb: 4'b1011, exp_lsb: 4'b1101, exp_par: 1'b1};
        vecs[1] = '{din: 4'b0110, exp_msb: 4'b0110, exp_lsb: 4'b0110, exp_par: 1'b0};
        vecs[2] = '{din: 4'b0001, exp_msb: 4'b0001, exp_lsb: 4'b1000, exp_par: 1'b1};
        vecs[3] = '{din: 4'b1111, exp_msb: 4'b1111, exp_lsb: 4'b1111, exp_par: 1'b0};
        vecs[4] = '{din: 4'b0000, exp_msb: 4'b0000, exp_lsb: 4'b0000, exp_par: 1'b0};
        vecs[5] = '{din: 4'b1100, exp_msb: 4'b1100, exp_lsb: 4'b0011, exp_par: 1'b0};

        drive(1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        chk("reset sout",       {31'd0, bm.sout},       32'd0);
        chk("reset sout_valid", {31'd0, bm.sout_valid}, 32'd0);
        chk("reset busy",       {31'd0, bm.busy},       32'd0);
        chk("reset done",       {31'd0, bm.done},       32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post-reset");

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            drive(1'b1, vecs[v].din);
            @(negedge clk);
            drive(1'b0, 4'b1010);
            for (int i = 0; i < W; i++) begin
                chk($sformatf("v%0d msb bit%0d", v, i), {31'd0, bm.sout}, {31'd0, vecs[v].exp_msb[W-1-i]});
                chk($sformatf("v%0d lsb bit%0d", v, i), {31'd0, bl.sout}, {31'd0, vecs[v].exp_lsb[W-1-i]});
                chk($sformatf("v%0d valid%0d", v, i),   {31'd0, bm.sout_valid}, 32'd1);
                chk($sformatf("v%0d busy%0d", v, i),    {31'd0, bm.busy}, 32'd1);
                chk($sformatf("v%0d done%0d", v, i),    {31'd0, bm.done}, {31'd0, (i == FL - 1)});
                chk($sformatf("v%0d ready%0d", v, i),   {31'd0, bm.load_ready}, {31'd0, (i == FL - 1)});
                @(negedge clk);
            end
            if (PAR == 1) begin
                chk($sformatf("v%0d msb parity", v), {31'd0, bm.sout}, {31'd0, vecs[v].exp_par});
                chk($sformatf("v%0d lsb parity", v), {31'd0, bl.sout}, {31'd0, vecs[v].exp_par});
                chk($sformatf("v%0d parity done", v), {31'd0, bm.done}, 32'd1);
                chk($sformatf("v%0d parity valid", v), {31'd0, bm.sout_valid}, 32'd1);
                @(negedge clk);
            end
            chk_idle($sformatf("v%0d end", v));
        end

        // Back-to-back: load_valid held; second word presented on the final frame cycle.
        begin
            logic [2*FL-1:0] exp_b;
            logic [2*FL-1:0] exp_d;
`ifdef PISO_SERIALIZER_PARITY_EN
            exp_b = 10'b10111_01001;
            exp_d = 10'b00001_00001;
`else
            exp_b = 8'b1011_0100;
            exp_d = 8'b0001_0001;
`endif
            drive(1'b1, 4'b1011);
            @(negedge clk);
            for (int i = 0; i < 2 * FL; i++) begin
                chk($sformatf("b2b bit%0d", i),   {31'd0, bm.sout},       {31'd0, exp_b[2*FL-1-i]});
                chk($sformatf("b2b valid%0d", i), {31'd0, bm.sout_valid}, 32'd1);
                chk($sformatf("b2b done%0d", i),  {31'd0, bm.done},       {31'd0, exp_d[2*FL-1-i]});
                if (i == FL - 1) drive(1'b1, 4'b0100);
                if (i == FL)     drive(1'b0, 4'b0000);
                @(negedge clk);
            end
            chk_idle("b2b end");
        end

        // Ignored load during the second bit of a frame.
        begin
            logic [FL-1:0] exp_i;
`ifdef PISO_SERIALIZER_PARITY_EN
            exp_i = 5'b10111;
`else
            exp_i = 4'b1011;
`endif
            drive(1'b1, 4'b1011);
            @(negedge clk);
            drive(1'b0, 4'b0000);
            for (int i = 0; i < FL; i++) begin
                if (i == 1) begin
                    chk("ign ready during bit2", {31'd0, bm.load_ready}, 32'd0);
                    drive(1'b1, 4'b1111);
                end else begin
                    drive(1'b0, 4'b0000);
                end
                chk($sformatf("ign bit%0d", i), {31'd0, bm.sout}, {31'd0, exp_i[FL-1-i]});
                chk($sformatf("ign done%0d", i), {31'd0, bm.done}, {31'd0, (i == FL - 1)});
                @(negedge clk);
            end
            chk_idle("ign end");
            @(negedge clk);
            chk("ign no second frame", {31'd0, bm.sout_valid}, 32'd0);
        end

        // Asynchronous reset mid-frame: outputs clear before any clock edge.
        drive(1'b1, 4'b1111);
        @(negedge clk);
        drive(1'b0, 4'b0000);
        @(negedge clk);
        chk("pre-reset sout", {31'd0, bm.sout}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async rst msb sout",       {31'd0, bm.sout},       32'd0);
        chk("async rst msb sout_valid", {31'd0, bm.sout_valid}, 32'd0);
        chk("async rst msb busy",       {31'd0, bm.busy},       32'd0);
        chk("async rst msb done",       {31'd0, bm.done},       32'd0);
        chk("async rst lsb sout",       {31'd0, bl.sout},       32'd0);
        chk("async rst lsb sout_valid", {31'd0, bl.sout_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after mid-frame reset");
        @(negedge clk);
        chk("no resend after reset", {31'd0, bm.sout_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
